// File: rtl/br_arb_wrr_burst_tracker.sv
// Burst tracker: holds burst_active/burst_count and decides whether the last grantee keeps the grant.
// Sticky decision is combinational; state moves only on an accepted grant (update_i).
module br_arb_wrr_burst_tracker #(
    parameter  int MaxWeight   = 4,
    localparam int WeightWidth = $clog2(MaxWeight + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   update_i,
    input  logic                   same_grant_i,
    input  logic                   last_req_i,
    input  logic [WeightWidth-1:0] last_weight_i,
    output logic                   sticky_o
);

    logic                   burst_active_q, burst_active_d;
    logic [WeightWidth-1:0] burst_count_q,  burst_count_d;

    // A weight lowered to or below the running count ends the burst immediately.
    assign sticky_o = burst_active_q && last_req_i && (burst_count_q < last_weight_i);

    always_comb begin
        burst_active_d = burst_active_q;
        burst_count_d  = burst_count_q;
        if (update_i) begin
            if (same_grant_i && burst_active_q) begin
                if (burst_count_q < WeightWidth'(MaxWeight)) begin
                    burst_count_d = burst_count_q + WeightWidth'(1);
                end
            end else begin
                burst_active_d = 1'b1;
                burst_count_d  = WeightWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_active_q <= 1'b0;
            burst_count_q  <= '0;
        end else begin
            burst_active_q <= burst_active_d;
            burst_count_q  <= burst_count_d;
        end
    end

endmodule

// File: rtl/br_arb_wrr.sv
// Weighted round-robin arbiter: a grantee keeps the grant for up to request_weight consecutive grants.
// Zero-latency grant from request/weight and state; state advances only on enabled, nonzero grants.
module br_arb_wrr #(
    parameter  int NumRequesters = 2,
    parameter  int MaxWeight     = 4,
    localparam int WeightWidth   = $clog2(MaxWeight + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable_priority_update,
    input  logic [NumRequesters-1:0]                  request,
    input  logic [NumRequesters-1:0][WeightWidth-1:0] request_weight,
    output logic [NumRequesters-1:0]                  grant
);

    localparam int IdxWidth  = $clog2(NumRequesters);
    localparam int IdxWidth1 = IdxWidth + 1;

    logic [NumRequesters-1:0] last_grant_q, last_grant_d;
    logic [NumRequesters-1:0] eff_req;
    logic [NumRequesters-1:0] rot_grant;
    logic [IdxWidth-1:0]      last_idx;
    logic [IdxWidth1-1:0]     rot_sum;
    logic                     rot_found;
    logic                     sticky;
    logic                     update;

    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            eff_req[i] = request[i] && (request_weight[i] != '0);
        end
    end

    always_comb begin
        last_idx = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (last_grant_q[i]) begin
                last_idx = IdxWidth'(i);
            end
        end
    end

    // Search starts one past the last grantee and wraps, so the last grantee is considered last.
    always_comb begin
        rot_grant = '0;
        rot_found = 1'b0;
        rot_sum   = '0;
        for (int k = 1; k <= NumRequesters; k++) begin
            rot_sum = {1'b0, last_idx} + IdxWidth1'(k);
            if (rot_sum >= IdxWidth1'(NumRequesters)) begin
                rot_sum = rot_sum - IdxWidth1'(NumRequesters);
            end
            if (!rot_found && eff_req[rot_sum[IdxWidth-1:0]]) begin
                rot_grant[rot_sum[IdxWidth-1:0]] = 1'b1;
                rot_found = 1'b1;
            end
        end
    end

    br_arb_wrr_burst_tracker #(
        .MaxWeight (MaxWeight)
    ) u_burst_tracker (
        .clk           (clk),
        .rst           (rst),
        .update_i      (update),
        .same_grant_i  (grant == last_grant_q),
        .last_req_i    (eff_req[last_idx]),
        .last_weight_i (request_weight[last_idx]),
        .sticky_o      (sticky)
    );

    assign grant  = sticky ? last_grant_q : rot_grant;
    assign update = enable_priority_update && (|grant);

    assign last_grant_d = update ? grant : last_grant_q;

    // Reset to the highest index so the rotation search begins at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= {1'b1, {(NumRequesters-1){1'b0}}};
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));
    a_grant_has_req: assert property (@(posedge clk) (grant & ~request) == '0);

    for (genvar g = 0; g < NumRequesters; g++) begin : g_weight_chk
        a_weight_legal: assert property (@(posedge clk) disable iff (rst)
            request_weight[g] <= WeightWidth'(MaxWeight));
    end

endmodule

// File: tb/tb_br_arb_wrr.sv
// Bench for br_arb_wrr: directed scenarios with fixed grant sequences plus randomized traffic,
// all compared against a rule-level reference model.
module tb_br_arb_wrr;

    localparam int N  = 4;
    localparam int MW = 3;
    localparam int WW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [N-1:0]         request;
    logic [N-1:0][WW-1:0] request_weight;
    logic [N-1:0]         grant;

    always #5 clk = ~clk;

    br_arb_wrr #(
        .NumRequesters (N),
        .MaxWeight     (MW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable_priority_update (en),
        .request                (request),
        .request_weight         (request_weight),
        .grant                  (grant)
    );

    int       checks = 0;
    int       errors = 0;
    int       w [N];
    bit [N-1:0] rq;
    bit       en_m;
    int       m_last;
    int       m_count;
    bit       m_active;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic bit eff(input int i);
        return rq[i] && (w[i] != 0);
    endfunction

    function automatic int ref_grant();
        if (m_active && eff(m_last) && (m_count < w[m_last])) return m_last;
        for (int k = 1; k <= N; k++) begin
            if (eff((m_last + k) % N)) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive();
        request = rq;
        en      = en_m;
        for (int i = 0; i < N; i++) request_weight[i] = WW'(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_last   = N - 1;
        m_active = 1'b0;
        m_count  = 0;
    endtask

    // exp_idx: -2 = model only, -1 = expect no grant, else expected grantee index.
    task automatic step(input string tag, input int exp_idx);
        int g;
        drive();
        @(negedge clk);
        g = ref_grant();
        chk(tag, grant, oh(g));
        if (exp_idx != -2) chk({tag, "_seq"}, grant, oh(exp_idx));
        if (en_m && g >= 0) begin
            if (g == m_last && m_active) begin
                if (m_count < MW) m_count++;
            end else begin
                m_last   = g;
                m_count  = 1;
                m_active = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    endtask

    int s31 [5]  = '{0, 1, 2, 3, 0};
    int s32 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    int s33 [6]  = '{2, 3, 0, 0, 0, 1};
    int s34 [3]  = '{0, 0, 1};
    int s36 [4]  = '{0, 0, 0, 1};

    initial begin
        rst  = 1'b1;
        en_m = 1'b1;
        rq   = '0;
        set_w(1, 1, 1, 1);
        drive();
        do_reset();

        // Reset state: nothing requested, then only index 3 requested.
        rq = 4'b0000; step("rst_idle", -1);
        rq = 4'b1000; step("rst_idx3", 3);

        do_reset();
        rq = 4'b1111;
        foreach (s31[i]) step("plain_rr", s31[i]);

        do_reset();
        set_w(3, 1, 2, 1);
        foreach (s32[i]) step("weighted", s32[i]);

        do_reset();
        set_w(3, 1, 1, 1);
        rq = 4'b1111; step("wd_first", 0);
        rq = 4'b1110; step("wd_drop", 1);
        rq = 4'b1111;
        foreach (s33[i]) step("wd_reraise", s33[i]);

        do_reset();
        set_w(2, 1, 1, 1);
        en_m = 1'b0;
        rq   = 4'b0001;
        for (int i = 0; i < 5; i++) step("en_low", 0);
        en_m = 1'b1;
        rq   = 4'b0011;
        foreach (s34[i]) step("en_high", s34[i]);

        do_reset();
        set_w(1, 1, 0, 1);
        rq = 4'b0100; step("zero_w", -1);
        rq = 4'b0110; step("zero_w_pair", 1);

        do_reset();
        set_w(3, 1, 1, 1);
        rq = 4'b1111; step("rst_mid_first", 0);
        do_reset();
        foreach (s36[i]) step("rst_mid", s36[i]);

        // Random traffic; inputs often held to let bursts develop.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    rq = N'($urandom_range(0, (1 << N) - 1));
                    for (int i = 0; i < N; i++) begin
                        if ($urandom_range(0, 3) == 0) w[i] = $urandom_range(0, MW);
                    end
                end
                en_m = ($urandom_range(0, 7) != 0);
                step("rand", -2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_arb_wrr.md
BR_ARB_WRR -- requirements
Module: br_arb_wrr

Interface
REQ-001 The block SHALL have parameter NumRequesters, default 2, giving the number of requesters; legal values are 2 and above.
REQ-002 The block SHALL have parameter MaxWeight, default 4, giving the largest legal burst weight; legal values are 1 and above.
REQ-003 The block SHALL derive WeightWidth = $clog2(MaxWeight+1) locally; it is not an overridable parameter.
REQ-004 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable_priority_update  input  1  when 1, a cycle with a grant updates the arbitration state.
REQ-008 request  input  NumRequesters  per-requester request.
REQ-009 request_weight  input  NumRequesters x WeightWidth  per-requester burst weight, read every cycle.
REQ-010 grant  output  NumRequesters  one-hot or zero grant, combinational from inputs and state.

Function
REQ-011 Effective request SHALL be request[i] && request_weight[i] != 0; a requester with weight 0 is never granted.
REQ-012 grant SHALL have zero latency from request and SHALL have at most one bit set; grant is nonzero iff any effective request is set.
REQ-013 State SHALL be last_grant (one-hot), burst_active (1 bit) and burst_count (WeightWidth bits).
REQ-014 Sticky case: if burst_active && effective request[L] && burst_count < request_weight[L], where L is the index of last_grant, then grant SHALL be last_grant.
REQ-015 Rotate case: otherwise grant SHALL go to the first effective request at or after index (L+1) mod NumRequesters, wrapping.
REQ-016 State SHALL update only in a cycle with enable_priority_update && |grant; in every other cycle it holds.
REQ-017 On update, if grant == last_grant && burst_active, burst_count SHALL increment, saturating at MaxWeight.
REQ-018 On any other update, last_grant SHALL load grant, burst_count SHALL load 1, and burst_active SHALL load 1.
REQ-019 With all weights equal to 1, the block SHALL behave as a plain round-robin arbiter.
REQ-020 Weight change mid-burst SHALL take effect in the same cycle.
- If the new weight is at or below burst_count, the burst ends and priority rotates.
REQ-021 Withdrawal mid-burst SHALL end the burst.
- The requester regains priority only through normal rotation, with a fresh count.
REQ-022 The block SHALL assert that grant is onehot0 and that grant implies request.
REQ-023 The block SHALL assert that every request_weight is at most MaxWeight, checked when rst is 0.

Reset
REQ-024 On rst, last_grant SHALL reset to one-hot index NumRequesters-1, burst_active to 0 and burst_count to 0, so index 0 has top priority.
REQ-025 During and after rst, grant SHALL follow REQ-014/015 from the reset state.
REQ-026 Reset asserted mid-burst SHALL discard the burst with no residual credit.

Structure
REQ-027 No shared package is needed; WeightWidth and the state types SHALL stay local to the module.
REQ-028 The burst tracker (burst_active, burst_count, sticky decision) SHALL be one sub-module, br_arb_wrr_burst_tracker.
REQ-029 The rotation priority encode SHALL stay in the top module.
REQ-030 A competent implementation SHALL fit in 120-400 lines of RTL.

Verification (NumRequesters=4, MaxWeight=3, enable_priority_update=1 unless stated)
REQ-031 Plain round robin: weights {1,1,1,1}, request=1111 after reset -> grant index sequence 0,1,2,3,0.
REQ-032 Weighted bursts: weights idx0..3 = {3,1,2,1}, request=1111 held -> grant index sequence 0,0,0,1,2,2,3,0,0,0.
REQ-033 Withdrawal: weight0=3, request=1111; after one grant to 0, drop req0 -> next grant is 1.
- Re-raise req0 -> 0 is next granted after 3, with 3 grants.
REQ-034 Enable low: enable=0, request=0001, weight0=2 for 5 cycles -> grant=0001 every cycle and no state change.
- Then enable=1, request=0011 -> grant sequence 0,0,1.
REQ-035 Zero weight: weight2=0, request=0100 -> grant=0000; request=0110 -> grant=0010.
REQ-036 Reset mid-burst: reset for one cycle after one grant to 0 (weight0=3, request=1111).
- After reset -> grants 0,0,0 then 1.
